pooling1: RTL and testbench

- Downstream consumer of the first convolution layer. Sits on the far end of that layer's finished/reply handshake.
- Captures the 2-channel 28x28 feature map, runs 2x2 stride-2 max pooling, and produces a 2-channel 14x14 map.
- Offers its result to the next layer through the same finished/reply handshake, with this block acting as the producer.

---
 rtl/pool_pkg.sv | 21 ++
 rtl/max4_signed.sv | 28 ++
 rtl/pooling1.sv | 166 ++++++++++++++++
 tb/tb_pooling1.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared state encoding, default sizes and flattened-index helper for the pooling1 layer.
package pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } pool_state_t;

    localparam int DEF_BITWIDTH = 32;
    localparam int DEF_IN_DIM   = 28;
    localparam int DEF_CHANNELS = 2;
    localparam int OUT_DIM      = DEF_IN_DIM / 2;
    localparam int N_OUT        = DEF_CHANNELS * OUT_DIM * OUT_DIM;

    // Offset of element [ch][row][col] in a channel-major, row-major map of side dim.
    function automatic int flat_idx(input int ch, input int row, input int col, input int dim);
        return (ch * dim + row) * dim + col;
    endfunction

endpackage

// File: rtl/max4_signed.sv
// Signed maximum of one 2x2 pooling window.
// Build option POOL_RELU_EN clamps negative results to zero.
module max4_signed #(
    parameter int BITWIDTH = 32
) (
    input  logic signed [BITWIDTH-1:0] a,
    input  logic signed [BITWIDTH-1:0] b,
    input  logic signed [BITWIDTH-1:0] c,
    input  logic signed [BITWIDTH-1:0] d,
    output logic signed [BITWIDTH-1:0] y
);

    logic signed [BITWIDTH-1:0] m_ab;
    logic signed [BITWIDTH-1:0] m_cd;
    logic signed [BITWIDTH-1:0] m_all;

    always_comb begin
        m_ab  = (a > b) ? a : b;
        m_cd  = (c > d) ? c : d;
        m_all = (m_ab > m_cd) ? m_ab : m_cd;
`ifdef POOL_RELU_EN
        y = m_all[BITWIDTH-1] ? '0 : m_all;
`else
        y = m_all;
`endif
    end

endmodule

// File: rtl/pooling1.sv
// 2x2 stride-2 max pooling between two finished/reply handshakes; one output element per cycle.
// Optional clamp of negative results enabled by defining POOL_RELU_EN.
module pooling1
    import pool_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int IN_DIM   = DEF_IN_DIM,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               enable,
    input  logic [CHANNELS*IN_DIM*IN_DIM*BITWIDTH-1:0]         featuremap_in,
    input  logic                                               finished_from_prev_device,
    output logic                                               reply_to_prev_device,
    output logic [CHANNELS*(IN_DIM/2)*(IN_DIM/2)*BITWIDTH-1:0] featuremap_out,
    output logic                                               finished_for_next_device,
    input  logic                                               reply_from_next_device,
    output pool_state_t                                        dbg_state
);

    localparam int HALF = IN_DIM / 2;
    localparam int NI   = CHANNELS * IN_DIM * IN_DIM;
    localparam int NO   = CHANNELS * HALF * HALF;
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RC_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int II_W = (NI > 1) ? $clog2(NI) : 1;
    localparam int OI_W = (NO > 1) ? $clog2(NO) : 1;

    pool_state_t state;
    pool_state_t state_nxt;

    logic                       armed;
    logic [CH_W-1:0]            ch_cnt;
    logic [RC_W-1:0]            r_cnt;
    logic [RC_W-1:0]            c_cnt;
    logic signed [BITWIDTH-1:0] buf_mem [NI];
    logic signed [BITWIDTH-1:0] out_mem [NO];

    logic                       capture;
    logic                       step;
    logic                       accept;
    logic                       last_col;
    logic                       last_row;
    logic                       last_ch;
    logic [II_W-1:0]            i00;
    logic [II_W-1:0]            i01;
    logic [II_W-1:0]            i10;
    logic [II_W-1:0]            i11;
    logic [OI_W-1:0]            o_idx;
    logic signed [BITWIDTH-1:0] pooled;

    assign last_col  = (c_cnt == RC_W'(HALF - 1));
    assign last_row  = (r_cnt == RC_W'(HALF - 1));
    assign last_ch   = (ch_cnt == CH_W'(CHANNELS - 1));
    assign dbg_state = state;

    // Top-left corner of the current window; the other three are fixed offsets from it.
    assign i00   = II_W'(flat_idx(int'(ch_cnt), 2 * int'(r_cnt), 2 * int'(c_cnt), IN_DIM));
    assign i01   = i00 + II_W'(1);
    assign i10   = i00 + II_W'(IN_DIM);
    assign i11   = i10 + II_W'(1);
    assign o_idx = OI_W'(flat_idx(int'(ch_cnt), int'(r_cnt), int'(c_cnt), HALF));

    max4_signed #(.BITWIDTH(BITWIDTH)) u_max4 (
        .a (buf_mem[i00]),
        .b (buf_mem[i01]),
        .c (buf_mem[i10]),
        .d (buf_mem[i11]),
        .y (pooled)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reply in DONE only counts once the downstream has actually seen finished high.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && finished_from_prev_device && armed) begin
                    capture   = 1'b1;
                    state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (enable) begin
                    step = 1'b1;
                    if (last_ch && last_row && last_col) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (enable && finished_for_next_device && reply_from_next_device) begin
                    accept    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed                    <= 1'b1;
            reply_to_prev_device     <= 1'b0;
            finished_for_next_device <= 1'b0;
            ch_cnt                   <= '0;
            r_cnt                    <= '0;
            c_cnt                    <= '0;
            for (int i = 0; i < NO; i++) begin
                out_mem[i] <= '0;
            end
        end else begin
            // Re-arm whenever upstream drops its level, regardless of state or enable.
            if (!finished_from_prev_device) begin
                armed <= 1'b1;
            end else if (capture) begin
                armed <= 1'b0;
            end
            if (enable) begin
                reply_to_prev_device     <= capture;
                finished_for_next_device <= (state == ST_DONE) && !accept;
            end
            if (step) begin
                out_mem[o_idx] <= pooled;
                if (last_col) begin
                    c_cnt <= '0;
                    if (last_row) begin
                        r_cnt  <= '0;
                        ch_cnt <= last_ch ? '0 : ch_cnt + CH_W'(1);
                    end else begin
                        r_cnt <= r_cnt + RC_W'(1);
                    end
                end else begin
                    c_cnt <= c_cnt + RC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NI; i++) begin
                buf_mem[i] <= featuremap_in[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    always_comb begin
        featuremap_out = '0;
        for (int i = 0; i < NO; i++) begin
            featuremap_out[i*BITWIDTH +: BITWIDTH] = out_mem[i];
        end
    end

endmodule

// File: tb/tb_pooling1.sv
// Bench for pooling1: in-bench max-pool model feeding an expected queue, per-cycle frame
// compare while finished is high, plus handshake, latency, enable and async-reset checks.
module tb_pooling1;
    import pool_pkg::*;

    localparam int BW = DEF_BITWIDTH;
    localparam int ID = DEF_IN_DIM;
    localparam int CH = DEF_CHANNELS;
    localparam int OD = ID / 2;
    localparam int NI = CH * ID * ID;
    localparam int NO = CH * OD * OD;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NI*BW-1:0]  featuremap_in;
    logic              fin_prev;
    logic              reply_prev;
    logic [NO*BW-1:0]  featuremap_out;
    logic              fin_next;
    logic              reply_next;
    pool_state_t       dbg_state;

    pooling1 dut (
        .clk                       (clk),
        .reset                     (reset),
        .enable                    (enable),
        .featuremap_in             (featuremap_in),
        .finished_from_prev_device (fin_prev),
        .reply_to_prev_device      (reply_prev),
        .featuremap_out            (featuremap_out),
        .finished_for_next_device  (fin_next),
        .reply_from_next_device    (reply_next),
        .dbg_state                 (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int reply_count = 0;
    int reply_run = 0;
    int cap_cyc = 0;
    int fin_rise_count = 0;
    int fin_rise_cyc = 0;
    logic fin_d = 1'b0;
    logic have_frame = 1'b0;
    logic signed [BW-1:0] in_vals [NI];
    logic signed [BW-1:0] cur_exp [NO];
    logic [BW-1:0] exp_q [$];

    task automatic check_eq(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic signed [BW-1:0] out_el(input int i);
        return featuremap_out[i*BW +: BW];
    endfunction

    // ---------------- scoreboard / compare (runs every cycle) ----------------
    task automatic monitor();
        int bad_i;
        if (!reset) begin
            have_frame = 1'b0;
            fin_d      = 1'b0;
            reply_run  = 0;
        end else begin
            if (reply_prev) begin
                if (reply_run == 0) begin
                    reply_count++;
                    cap_cyc = cyc;
                end
                reply_run++;
            end else begin
                if (reply_run != 0) check_eq("reply_pulse_width", reply_run, 1);
                reply_run = 0;
            end
            if (fin_next && !fin_d) begin
                fin_rise_count++;
                fin_rise_cyc = cyc;
                if (exp_q.size() >= NO) begin
                    for (int i = 0; i < NO; i++) cur_exp[i] = exp_q.pop_front();
                    have_frame = 1'b1;
                end else begin
                    check_eq("expected_frame_available", exp_q.size(), NO);
                end
            end
            if (fin_next && have_frame) begin
                bad_i = -1;
                for (int i = 0; i < NO; i++) begin
                    if (bad_i < 0 && out_el(i) !== cur_exp[i]) bad_i = i;
                end
                if (bad_i < 0) bad_i = 0;
                check_eq($sformatf("frame_out[%0d]", bad_i), out_el(bad_i), cur_exp[bad_i]);
            end
            if (!fin_next) have_frame = 1'b0;
            fin_d = fin_next;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    // ---------------- reference model ----------------
    task automatic push_model();
        logic signed [BW-1:0] m;
        logic signed [BW-1:0] v;
        for (int ch = 0; ch < CH; ch++) begin
            for (int r = 0; r < OD; r++) begin
                for (int c = 0; c < OD; c++) begin
                    m = in_vals[ch*ID*ID + (2*r)*ID + 2*c];
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            v = in_vals[ch*ID*ID + (2*r+dr)*ID + (2*c+dc)];
                            if (v > m) m = v;
                        end
                    end
`ifdef POOL_RELU_EN
                    if (m < 0) m = 0;
`endif
                    exp_q.push_back(m);
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic fill(input int mode);
        for (int i = 0; i < NI; i++) begin
            case (mode)
                0:       in_vals[i] = 32'sd1;
                1:       in_vals[i] = i;
                2:       in_vals[i] = $signed($urandom());
                default: in_vals[i] = $signed($urandom_range(0, 7)) - 32'sd4;
            endcase
        end
    endtask

    task automatic drive_frame();
        for (int i = 0; i < NI; i++) featuremap_in[i*BW +: BW] = in_vals[i];
    endtask

    task automatic wait_reply(input int budget);
        int start;
        int n;
        start = reply_count;
        n = 0;
        while (reply_count == start && n < budget) begin
            tick();
            n++;
        end
        check_eq("reply_seen", reply_count - start, 1);
        push_model();
    endtask

    task automatic wait_fin(input int budget, input int exp_lat);
        int start;
        int n;
        start = fin_rise_count;
        n = 0;
        while (fin_rise_count == start && n < budget) begin
            tick();
            n++;
        end
        check_eq("finished_seen", fin_rise_count - start, 1);
        check_eq("capture_to_finished_latency", fin_rise_cyc - cap_cyc, exp_lat);
    endtask

    task automatic accept_frame(input int hold);
        repeat (hold) tick();
        check_eq("finished_held", fin_next, 1);
        reply_next = 1'b1;
        tick();
        reply_next = 1'b0;
        check_eq("finished_drop_after_reply", fin_next, 0);
    endtask

    task automatic start_frame(input int mode);
        fin_prev = 1'b0;
        tick();
        fill(mode);
        drive_frame();
        fin_prev = 1'b1;
        wait_reply(5);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rc0;
        reset         = 1'b0;
        enable        = 1'b1;
        fin_prev      = 1'b0;
        reply_next    = 1'b0;
        featuremap_in = '0;
        #1;
        check_eq("reset_reply", reply_prev, 0);
        check_eq("reset_finished", fin_next, 0);
        check_eq("reset_out_ones", $countones(featuremap_out), 0);
        check_eq("reset_state", int'(dbg_state), int'(ST_IDLE));
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // all-ones frame, upstream level held high throughout
        fill(0);
        drive_frame();
        fin_prev = 1'b1;
        wait_reply(5);
        rc0 = reply_count;
        wait_fin(500, 393);
        check_eq("ones_out_first", out_el(0), 1);
        check_eq("ones_out_last", out_el(NO-1), 1);
        accept_frame(3);
        repeat (20) tick();
        check_eq("no_recapture_while_held", reply_count - rc0, 0);

        // index-valued frame after a one-cycle drop; long withheld reply
        start_frame(1);
        fin_prev = 1'b0;
        wait_fin(500, 393);
        check_eq("index_out_0_0_0", out_el(0), 29);
        check_eq("index_out_1_13_13", out_el(NO-1), 1567);
        accept_frame(50);

        // negative window in the first position
        start_frame(2);
        fin_prev = 1'b0;
        wait_fin(500, 393);
        accept_frame(1);
        fill(2);
        in_vals[0]    = -32'sd5;
        in_vals[1]    = -32'sd3;
        in_vals[ID]   = -32'sd9;
        in_vals[ID+1] = -32'sd7;
        drive_frame();
        fin_prev = 1'b1;
        wait_reply(5);
        fin_prev = 1'b0;
        wait_fin(500, 393);
`ifdef POOL_RELU_EN
        check_eq("neg_window_out", out_el(0), 0);
`else
        check_eq("neg_window_out", out_el(0), -3);
`endif
        accept_frame($urandom_range(1, 8));

        // tie-heavy frame with enable low for 10 cycles mid-compute
        start_frame(3);
        fin_prev = 1'b0;
        repeat (100) tick();
        enable = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        wait_fin(600, 403);
        accept_frame(2);

        // random frame; upstream scrambles its bus right after the reply
        start_frame(2);
        fin_prev = 1'b0;
        for (int i = 0; i < NI; i++) featuremap_in[i*BW +: BW] = $urandom();
        wait_fin(500, 393);
        accept_frame(4);

        // reset in the middle of compute aborts the frame
        start_frame(2);
        fin_prev = 1'b0;
        repeat (100) tick();
        #2;
        reset = 1'b0;
        #1;
        check_eq("midreset_out_ones", $countones(featuremap_out), 0);
        check_eq("midreset_finished", fin_next, 0);
        check_eq("midreset_reply", reply_prev, 0);
        check_eq("midreset_state", int'(dbg_state), int'(ST_IDLE));
        repeat (2) tick();
        reset = 1'b1;
        exp_q.delete();
        rc0 = fin_rise_count;
        repeat (450) tick();
        check_eq("no_finished_after_reset", fin_rise_count - rc0, 0);
        check_eq("idle_after_reset", int'(dbg_state), int'(ST_IDLE));

        // recovery frame
        start_frame(3);
        fin_prev = 1'b0;
        wait_fin(500, 393);
        accept_frame(2);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
